// File: rtl/pio_host_cmd.sv
// pio_host_cmd -- host command front-end for the pio block.
//
// Collects framed commands from a host byte stream (valid/ready), issues each
// one to pio as a single-cycle action strobe with mindex/index/din, and after
// a pull (action 3) returns the sampled pio dout to the host, LSB first.
//
// Frame: hdr {action[7:4], mindex[3:2], rsvd[1:0]}, idx {ign[7:5], index[4:0]},
//        then din bytes 0..3 little-endian.
//
// Build option: define PIO_HOST_CMD_CKSUM_EN to add a 7th frame byte holding
// the XOR of bytes 0..5, and a 5th response byte holding the XOR of the data.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   rx_data/valid/ready  host byte input stream
//   tx_data/valid/ready  response byte output stream
//   action, mindex,      command outputs to pio (action non-zero one cycle
//   index, din           per command; the others hold between commands)
//   dout                 pio read data, sampled RD_LAT cycles after a pull
//   busy                 frame in progress or response pending
//   err                  sticky error: bad header, timeout, checksum mismatch
module pio_host_cmd #(
  parameter int TIMEOUT = 1000,
  parameter int RD_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  output logic [4:0]  index,
  output logic [31:0] din,
  input  logic [31:0] dout,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    IDX   = 3'd1,
    DATA  = 3'd2,
    CKS   = 3'd3,
    ISSUE = 3'd4,
    RDW   = 3'd5,
    RESP  = 3'd6
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    RD_LAST = 4'(RD_LAT - 1);
`ifdef PIO_HOST_CMD_CKSUM_EN
  localparam logic [2:0]    RESP_LAST = 3'd4;

  // XOR of the four bytes of a word (response check byte)
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction
`else
  localparam logic [2:0]    RESP_LAST = 3'd3;
`endif

  state_t        state_r, state_next;
  logic [3:0]    act_hold_r, act_next;
  logic [1:0]    mi_hold_r, mi_next;
  logic [4:0]    idx_hold_r, idx_next;
  logic [31:0]   din_hold_r, din_next;
  logic [1:0]    bcnt_r, bcnt_next;
  logic [TW-1:0] to_cnt_r, to_next;
  logic [3:0]    rd_cnt_r, rd_next;
  logic [2:0]    rcnt_r, rcnt_next;
  logic [31:0]   resp_r, resp_next;
  logic [7:0]    tx_byte_next;
  logic          err_set_s;
  logic          xfer_s;
`ifdef PIO_HOST_CMD_CKSUM_EN
  logic [7:0]    cks_r, cks_next;
`endif

  logic [3:0]  action_r;
  logic [1:0]  mindex_r;
  logic [4:0]  index_r;
  logic [31:0] din_r;
  logic        rx_ready_r, tx_valid_r, busy_r, err_r;
  logic [7:0]  tx_data_r;

  assign xfer_s = rx_valid && rx_ready_r;

  // Frame parser / command sequencer next-state logic
  always_comb begin
    state_next = state_r;
    act_next   = act_hold_r;
    mi_next    = mi_hold_r;
    idx_next   = idx_hold_r;
    din_next   = din_hold_r;
    bcnt_next  = bcnt_r;
    to_next    = to_cnt_r;
    rd_next    = rd_cnt_r;
    rcnt_next  = rcnt_r;
    resp_next  = resp_r;
    err_set_s  = 1'b0;
`ifdef PIO_HOST_CMD_CKSUM_EN
    cks_next   = cks_r;
`endif
    case (state_r)
      HDR: begin
        to_next = {TW{1'b0}};
        if (xfer_s) begin
          if (rx_data[7:4] == 4'd0) begin
            state_next = HDR;              // sync/NOP byte
          end else if (rx_data[7:4] <= 4'd9) begin
            act_next   = rx_data[7:4];
            mi_next    = rx_data[3:2];
            state_next = IDX;
`ifdef PIO_HOST_CMD_CKSUM_EN
            cks_next   = rx_data;
`endif
          end else begin
            err_set_s  = 1'b1;
          end
        end else begin
          state_next = HDR;
        end
      end
      IDX, DATA, CKS: begin
        if (xfer_s) begin
          to_next = {TW{1'b0}};
`ifdef PIO_HOST_CMD_CKSUM_EN
          cks_next = cks_r ^ rx_data;
`endif
          if (state_r == IDX) begin
            idx_next   = rx_data[4:0];
            bcnt_next  = 2'd0;
            state_next = DATA;
          end else if (state_r == DATA) begin
            din_next  = {rx_data, din_hold_r[31:8]};
            bcnt_next = bcnt_r + 2'd1;
            if (bcnt_r == 2'd3) begin
`ifdef PIO_HOST_CMD_CKSUM_EN
              state_next = CKS;
`else
              state_next = ISSUE;
`endif
            end else begin
              state_next = DATA;
            end
          end else begin
`ifdef PIO_HOST_CMD_CKSUM_EN
            if (rx_data == cks_r) begin
              state_next = ISSUE;
            end else begin
              err_set_s  = 1'b1;
              state_next = HDR;
            end
`else
            state_next = HDR;
`endif
          end
        end else if (to_cnt_r == TO_LAST) begin
          // Host went quiet mid-frame: drop the partial frame
          err_set_s  = 1'b1;
          to_next    = {TW{1'b0}};
          state_next = HDR;
        end else begin
          to_next = to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ISSUE: begin
        rd_next    = 4'd0;
        state_next = (act_hold_r == 4'd3) ? RDW : HDR;
      end
      RDW: begin
        if (rd_cnt_r == RD_LAST) begin
          resp_next  = dout;
          rcnt_next  = 3'd0;
          state_next = RESP;
        end else begin
          rd_next = rd_cnt_r + 4'd1;
        end
      end
      RESP: begin
        if (tx_ready && tx_valid_r) begin
          if (rcnt_r == RESP_LAST) begin
            state_next = HDR;
          end else begin
            rcnt_next = rcnt_r + 3'd1;
          end
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = HDR;
    endcase
  end

  // Response byte selection for the next cycle
  always_comb begin
    tx_byte_next = 8'h00;
    case (rcnt_next)
      3'd0:    tx_byte_next = resp_next[7:0];
      3'd1:    tx_byte_next = resp_next[15:8];
      3'd2:    tx_byte_next = resp_next[23:16];
      3'd3:    tx_byte_next = resp_next[31:24];
`ifdef PIO_HOST_CMD_CKSUM_EN
      3'd4:    tx_byte_next = xor_bytes(resp_next);
`endif
      default: tx_byte_next = 8'h00;
    endcase
  end

  // State, holding registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= HDR;
      act_hold_r <= 4'd0;
      mi_hold_r  <= 2'd0;
      idx_hold_r <= 5'd0;
      din_hold_r <= 32'd0;
      bcnt_r     <= 2'd0;
      to_cnt_r   <= {TW{1'b0}};
      rd_cnt_r   <= 4'd0;
      rcnt_r     <= 3'd0;
      resp_r     <= 32'd0;
`ifdef PIO_HOST_CMD_CKSUM_EN
      cks_r      <= 8'd0;
`endif
      action_r   <= 4'd0;
      mindex_r   <= 2'd0;
      index_r    <= 5'd0;
      din_r      <= 32'd0;
      rx_ready_r <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'd0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_next;
      act_hold_r <= act_next;
      mi_hold_r  <= mi_next;
      idx_hold_r <= idx_next;
      din_hold_r <= din_next;
      bcnt_r     <= bcnt_next;
      to_cnt_r   <= to_next;
      rd_cnt_r   <= rd_next;
      rcnt_r     <= rcnt_next;
      resp_r     <= resp_next;
`ifdef PIO_HOST_CMD_CKSUM_EN
      cks_r      <= cks_next;
`endif
      // Outputs are loaded on the edge into their state so they are valid in it
      action_r <= (state_next == ISSUE) ? act_next : 4'd0;
      if (state_next == ISSUE) begin
        mindex_r <= mi_next;
        index_r  <= idx_next;
        din_r    <= din_next;
      end
      rx_ready_r <= (state_next == HDR) || (state_next == IDX) ||
                    (state_next == DATA) || (state_next == CKS);
      tx_valid_r <= (state_next == RESP);
      tx_data_r  <= (state_next == RESP) ? tx_byte_next : 8'h00;
      busy_r     <= (state_next != HDR);
      err_r      <= err_r | err_set_s;
    end
  end

  assign action   = action_r;
  assign mindex   = mindex_r;
  assign index    = index_r;
  assign din      = din_r;
  assign rx_ready = rx_ready_r;
  assign tx_valid = tx_valid_r;
  assign tx_data  = tx_data_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule

// File: tb/tb_pio_host_cmd.sv
// Self-checking bench for pio_host_cmd: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_pio_host_cmd;
  localparam int TO  = 40;
  localparam int RDL = 2;
`ifdef PIO_HOST_CMD_CKSUM_EN
  localparam int NRESP = 5;
`else
  localparam int NRESP = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [3:0]  action;
  logic [1:0]  mindex;
  logic [4:0]  index;
  logic [31:0] din;
  logic [31:0] dout = 32'h0;
  logic        busy;
  logic        err;

  pio_host_cmd #(.TIMEOUT(TO), .RD_LAT(RDL)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .action(action), .mindex(mindex), .index(index), .din(din),
    .dout(dout), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  a;
    logic [1:0]  m;
    logic [4:0]  i;
    logic [31:0] d;
    int          c;
  } strobe_t;
  strobe_t stq[$];

  // Record every cycle in which a strobe is visible
  always @(negedge clk) begin
    if (action !== 4'd0) stq.push_back('{action, mindex, index, din, cyc});
  end

  logic [7:0] fr [0:6];
  int         fr_n;

  function automatic void mk_frame(input logic [3:0] a, input logic [1:0] m,
                                   input logic [1:0] rsv, input logic [4:0] ix,
                                   input logic [2:0] hi, input logic [31:0] d);
    fr[0] = {a, m, rsv};
    fr[1] = {hi, ix};
    fr[2] = d[7:0];
    fr[3] = d[15:8];
    fr[4] = d[23:16];
    fr[5] = d[31:24];
`ifdef PIO_HOST_CMD_CKSUM_EN
    fr[6] = fr[0] ^ fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5];
    fr_n  = 7;
`else
    fr[6] = 8'h00;
    fr_n  = 6;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_byte_ready: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
    last_xfer_cyc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < fr_n; i++) begin
      send_byte(fr[i]);
      if (gap_max > 0 && i < fr_n - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  // Collect one response byte; ok=0 if tx_valid never rose
  task automatic get_tx(input int stall, output logic [7:0] b, output bit ok);
    int w = 0;
    while (tx_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = (tx_valid === 1'b1);
    b  = tx_data;
    repeat (stall) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({action, mindex, index, din, tx_valid, tx_data, rx_ready, busy, err} !== 56'd0) begin
      failures++;
      $display("FAIL reset_outputs: got a=%h m=%h i=%h d=%h tv=%b td=%h rr=%b b=%b e=%b required all 0",
               action, mindex, index, din, tx_valid, tx_data, rx_ready, busy, err);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rx_ready=%b busy=%b required 1 0", rx_ready, busy);
    end
  endtask

  task automatic test_instr_write();
    stq.delete();
    mk_frame(4'd1, 2'd0, 2'd0, 5'd5, 3'd0, 32'h0000_1234);
    send_frame(0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL iw_busy_issue: busy=%b required 1", busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (stq.size() != 1) begin
      failures++;
      $display("FAIL iw_strobe_count: got %0d required 1", stq.size());
    end else begin
      checks++;
      if (stq[0].a !== 4'd1 || stq[0].m !== 2'd0 || stq[0].i !== 5'd5 || stq[0].d !== 32'h1234) begin
        failures++;
        $display("FAIL iw_fields: got a=%h m=%h i=%h d=%h required 1 0 05 00001234",
                 stq[0].a, stq[0].m, stq[0].i, stq[0].d);
      end
      checks++;
      if (stq[0].c != last_xfer_cyc) begin
        failures++;
        $display("FAIL iw_latency: strobe cycle %0d required %0d", stq[0].c, last_xfer_cyc);
      end
    end
    checks++;
    if (busy !== 1'b0 || din !== 32'h1234 || index !== 5'd5) begin
      failures++;
      $display("FAIL iw_hold: busy=%b din=%h index=%h required 0 00001234 05", busy, din, index);
    end
  endtask

  task automatic test_pull();
    logic [7:0] exp_b [0:4];
    logic [7:0] b;
    bit ok;
    int w = 0;
    stq.delete();
    dout = 32'hDEAD_BEEF;
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    exp_b[4] = 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE;
    mk_frame(4'd3, 2'd1, 2'd0, 5'd0, 3'd0, 32'h0);
    send_frame(0);
    while (tx_valid !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (stq.size() != 1) begin
      failures++;
      $display("FAIL pull_strobe_count: got %0d required 1", stq.size());
    end else begin
      checks++;
      if (stq[0].a !== 4'd3 || stq[0].m !== 2'd1) begin
        failures++;
        $display("FAIL pull_fields: got a=%h m=%h required 3 1", stq[0].a, stq[0].m);
      end
      checks++;
      if (cyc != stq[0].c + RDL + 1) begin
        failures++;
        $display("FAIL pull_resp_latency: tx_valid at cycle %0d required %0d", cyc, stq[0].c + RDL + 1);
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hEF || rx_ready !== 1'b0) begin
        failures++;
        $display("FAIL pull_backpressure: tv=%b td=%h rr=%b required 1 ef 0", tx_valid, tx_data, rx_ready);
      end
      @(negedge clk);
    end
    for (int k = 0; k < NRESP; k++) begin
      get_tx(0, b, ok);
      checks++;
      if (!ok || b !== exp_b[k]) begin
        failures++;
        $display("FAIL pull_byte%0d: got %h valid=%b required %h", k, b, ok, exp_b[k]);
      end
    end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pull_done: tv=%b busy=%b required 0 0", tx_valid, busy);
    end
  endtask

  task automatic test_headers();
    stq.delete();
    send_byte(8'h00);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || stq.size() != 0) begin
      failures++;
      $display("FAIL hdr_nop: err=%b busy=%b strobes=%0d required 0 0 0", err, busy, stq.size());
    end
    send_byte(8'hA0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || stq.size() != 0) begin
      failures++;
      $display("FAIL hdr_bad: err=%b busy=%b strobes=%0d required 1 0 0", err, busy, stq.size());
    end
    mk_frame(4'd6, 2'd0, 2'd0, 5'd0, 3'd0, 32'h0000_000F);
    send_frame(0);
    repeat (2) @(negedge clk);
    checks++;
    if (stq.size() != 1) begin
      failures++;
      $display("FAIL hdr_recover_count: got %0d required 1", stq.size());
    end else begin
      checks++;
      if (stq[0].a !== 4'd6 || stq[0].d !== 32'hF) begin
        failures++;
        $display("FAIL hdr_recover: got a=%h d=%h required 6 0000000f", stq[0].a, stq[0].d);
      end
    end
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    stq.delete();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL to_err_cleared: err=%b required 0", err);
    end
    send_byte(8'h70);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL to_early: err=%b busy=%b required 0 1", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || stq.size() != 0) begin
      failures++;
      $display("FAIL to_fire: err=%b busy=%b strobes=%0d required 1 0 0", err, busy, stq.size());
    end
    mk_frame(4'd7, 2'd2, 2'd0, 5'd9, 3'd0, 32'hCAFE_0042);
    send_frame(0);
    repeat (2) @(negedge clk);
    checks++;
    if (stq.size() != 1) begin
      failures++;
      $display("FAIL to_next_frame_count: got %0d required 1", stq.size());
    end else begin
      checks++;
      if (stq[0].a !== 4'd7 || stq[0].m !== 2'd2 || stq[0].i !== 5'd9 || stq[0].d !== 32'hCAFE_0042) begin
        failures++;
        $display("FAIL to_next_frame: got a=%h m=%h i=%h d=%h required 7 2 09 cafe0042",
                 stq[0].a, stq[0].m, stq[0].i, stq[0].d);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [1:0]  m;
    logic [4:0]  ix;
    logic [31:0] d, rd;
    logic [7:0]  b, eb;
    bit ok;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      a  = 4'($urandom_range(1, 9));
      m  = 2'($urandom);
      ix = 5'($urandom);
      d  = $urandom;
      rd = $urandom;
      dout = rd;
      stq.delete();
      mk_frame(a, m, 2'($urandom), ix, 3'($urandom), d);
      send_frame(3);
      @(negedge clk);
      checks++;
      if (stq.size() != 1) begin
        failures++;
        $display("FAIL rnd%0d_count: got %0d required 1", n, stq.size());
      end else begin
        checks++;
        if (stq[0].a !== a || stq[0].m !== m || stq[0].i !== ix || stq[0].d !== d ||
            stq[0].c != last_xfer_cyc) begin
          failures++;
          $display("FAIL rnd%0d_strobe: got a=%h m=%h i=%h d=%h c=%0d required %h %h %h %h %0d",
                   n, stq[0].a, stq[0].m, stq[0].i, stq[0].d, stq[0].c, a, m, ix, d, last_xfer_cyc);
        end
      end
      if (a == 4'd3) begin
        for (int k = 0; k < NRESP; k++) begin
          eb = (k < 4) ? 8'(rd >> (8 * k)) : (rd[7:0] ^ rd[15:8] ^ rd[23:16] ^ rd[31:24]);
          get_tx($urandom_range(0, 2), b, ok);
          checks++;
          if (!ok || b !== eb) begin
            failures++;
            $display("FAIL rnd%0d_tx%0d: got %h valid=%b required %h", n, k, b, ok, eb);
          end
        end
      end
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || stq.size() != 1) begin
        failures++;
        $display("FAIL rnd%0d_idle: busy=%b tv=%b strobes=%0d required 0 0 1", n, busy, tx_valid, stq.size());
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL rnd_err: err=%b required 0", err);
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [7:0] b;
    bit ok;
    stq.delete();
    dout = 32'h1234_5678;
    mk_frame(4'd3, 2'd3, 2'd0, 5'd1, 3'd0, 32'h0);
    send_frame(0);
    get_tx(0, b, ok);
    get_tx(0, b, ok);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin
      failures++;
      $display("FAIL rmr_pre: tv=%b td=%h required 1 34", tx_valid, tx_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({action, mindex, index, din, tx_valid, tx_data, rx_ready, busy, err} !== 56'd0) begin
      failures++;
      $display("FAIL rmr_async: got a=%h m=%h i=%h d=%h tv=%b td=%h rr=%b b=%b e=%b required all 0",
               action, mindex, index, din, tx_valid, tx_data, rx_ready, busy, err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0 || stq.size() != 1) begin
      failures++;
      $display("FAIL rmr_after: rr=%b busy=%b strobes=%0d required 1 0 1", rx_ready, busy, stq.size());
    end
  endtask

`ifdef PIO_HOST_CMD_CKSUM_EN
  task automatic test_cksum();
    do_reset();
    stq.delete();
    mk_frame(4'd2, 2'd1, 2'd3, 5'd17, 3'd5, 32'h0BAD_F00D);
    send_frame(0);
    repeat (2) @(negedge clk);
    checks++;
    if (stq.size() != 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL cks_good: strobes=%0d err=%b required 1 0", stq.size(), err);
    end
    stq.delete();
    fr[6] = fr[6] ^ 8'h01;
    send_frame(0);
    repeat (2) @(negedge clk);
    checks++;
    if (stq.size() != 0 || err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cks_bad: strobes=%0d err=%b busy=%b required 0 1 0", stq.size(), err, busy);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_instr_write();
    test_pull();
    test_headers();
    test_timeout();
    test_random();
    test_reset_mid_resp();
`ifdef PIO_HOST_CMD_CKSUM_EN
    test_cksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_host_cmd.md
Name: pio_host_cmd

Overview:
- Upstream command front-end for the pio block. Accepts a byte stream from a host link (UART/SPI byte receiver) with a valid/ready handshake.
- Assembles framed commands and issues them as single-cycle `action` strobes with `mindex`/`index`/`din` to pio.
- After a pull command (action 3), samples pio `dout` and returns it to the host as 4 bytes on a byte output stream.

Parameters:
- TIMEOUT, 1000, inter-byte timeout in clk cycles; a partial frame is abandoned when exceeded.
- RD_LAT, 2, cycles from the action-3 strobe to the `dout` sample (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  host byte in
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte out
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host link accepts tx_data
- action  out  4  pio action strobe, non-zero for exactly one cycle per command
- mindex  out  2  machine index to pio
- index  out  5  instruction/pend index to pio
- din  out  32  data word to pio
- dout  in  32  pio read data
- busy  out  1  frame in progress or response pending
- err  out  1  sticky error flag, cleared by reset only

Behaviour:
- Reset (reset low, async): state=HDR; action=0, mindex=0, index=0, din=0, tx_valid=0, tx_data=0, rx_ready=0 during reset, err=0, busy=0, timeout counter=0.
- Frame format: 6 bytes (7 with the optional checksum).
  - Byte 0, header: [7:4]=action, [3:2]=mindex, [1:0] reserved (ignored).
  - Byte 1: [4:0]=index, [7:5] ignored.
  - Bytes 2..5: din little-endian (byte 2 = din[7:0]).
- A byte is transferred when rx_valid && rx_ready.
- rx_ready=1 only in HDR, IDX, DATA and CKS.
- States and transitions:
  - HDR: on a byte, if header action==0 the byte is discarded and the state stays HDR (sync/NOP). If action in 1..9, latch action and mindex, go to IDX. If action >9, set err and stay HDR.
  - IDX: latch index, clear byte counter, go to DATA.
  - DATA: shift bytes into a holding register. After the 4th byte go to CKS (macro defined) or ISSUE.
  - ISSUE: one cycle. Drive action=latched value. mindex/index/din outputs update from the holding registers in this same cycle. Next state: RDW if action==3, else HDR.
  - RDW: count RD_LAT cycles after ISSUE. On the final cycle capture dout into the response register, go to RESP with byte count 0.
  - RESP: tx_valid=1, tx_data=response byte[count], LSB first. Advance on tx_ready. After byte 3 is accepted, tx_valid drops the same edge and the state goes to HDR.
- Output holding: mindex/index/din change only in ISSUE and hold otherwise. action=0 in every cycle except ISSUE.
- Latency: ISSUE follows the last accepted frame byte by exactly 1 cycle.
- Timeout: counter clears on every accepted byte and counts while in IDX/DATA/CKS. When it reaches TIMEOUT, set err and return to HDR, discarding the partial frame. The counter does not run in HDR, ISSUE, RDW or RESP.
- Backpressure: while in RESP, rx_ready=0 and incoming bytes wait. tx_valid/tx_data stay stable until accepted.
- busy=1 in every state except HDR.
- Reset asserted mid-frame or mid-response: immediate return to the reset values above. No partial action strobe is ever emitted.

Optional Feature:
- Macro: PIO_HOST_CMD_CKSUM_EN.
- Defined: a 7th byte (CKS state) carries the XOR of bytes 0..5.
  - Match -> ISSUE.
  - Mismatch -> set err, no strobe, return to HDR.
  - Pull responses carry a 5th byte = XOR of the 4 data bytes, sent after the data bytes.
- Not defined: no CKS state, 6-byte frames, 4-byte responses. Byte 6 of a host frame would be parsed as a new header.

Test Plan:
- Instruction write: frame 0x10,0x05,0x34,0x12,0x00,0x00 -> one cycle with action=1, index=5, mindex=0, din=0x00001234, exactly 1 cycle after the last byte; busy returns to 0.
- Pull readback: frame 0x34,0,0,0,0,0 with dout=0xDEADBEEF -> action=3, mindex=1 strobe. After RD_LAT=2 cycles, tx bytes EF,BE,AD,DE. With tx_ready held low for 5 cycles, tx_data stays 0xEF and rx_ready stays 0.
- Invalid/NOP headers: 0x00 -> ignored, no err. 0xA0 -> err=1, no strobe. Then a valid 0x60 frame with din=0x0000000F -> action=6, din=0xF.
- Timeout: send 0x70,0x00,0x11 then idle TIMEOUT cycles -> err=1, state back to HDR, no strobe. Next full frame issues normally.
- Reset mid-response: assert reset after 2 tx bytes -> tx_valid=0 and all outputs 0 immediately, with no clock edge needed.
- Checksum (macro defined): a correct 7-byte frame issues. A frame with a corrupted XOR -> err=1, no action strobe.
